// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath width, reset vector and the
// PC-tagged instruction entry passed from prefetch to decode.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Canonical NOP (addi x0, x0, 0) injected by IF/ID on a flush.
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Sequential fetch address; wraps naturally modulo 2^XLEN.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with occupancy count and a synchronous flush.
// Clear has priority over push and pop in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // NOTE: the storage array has no reset; an entry is only observable once
  // count covers it, so clearing it would add reset fan-out for nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch between imem and IF/ID: credit-limited in-order fetch,
// PC-tagged buffering, and redirect flush that discards stale responses.
module fetch_prefetch_buffer
  import cpu_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  input  logic            out_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   count;
  logic [CW:0]     credits_used;

  fetch_entry_t push_entry;
  fetch_entry_t head;
  fetch_entry_t last_head;
  fetch_entry_t shown;

  logic fifo_full;
  logic fifo_empty;
  logic req_fire;
  logic push;
  logic pop;

  // Buffered plus in-flight fetches never exceed DEPTH, so every accepted
  // response is guaranteed a free slot.
  assign credits_used  = {1'b0, count} + {1'b0, outstanding};
  assign mem_req_valid = ~reset & ~redirect_valid & (credits_used < (CW+1)'(DEPTH));
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid & mem_req_ready;

  assign push       = ~reset & mem_resp_valid & (drop_cnt == '0) & ~redirect_valid;
  assign push_entry = '{pc: resp_pc, instr: mem_resp_data};

  assign out_valid = ~reset & ~redirect_valid & ~fifo_empty;
  assign pop       = out_valid & out_ready;

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (redirect_valid),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      last_head   <= '0;
    end else begin
      if (!fifo_empty) last_head <= head;
      outstanding <= outstanding + CW'(req_fire) - CW'(mem_resp_valid);
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        drop_cnt <= outstanding - CW'(mem_resp_valid);
      end else begin
        if (req_fire) fetch_pc <= next_pc(fetch_pc);
        if (push)     resp_pc  <= next_pc(resp_pc);
        if (mem_resp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  // NOTE: the combinational block assigns its output first on every path,
  // so no latch can be inferred.
  always_comb begin
    shown = fifo_empty ? last_head : head;
    if (reset) shown = '0;
  end

  assign out_pc    = shown.pc;
  assign out_instr = shown.instr;

  a_no_overflow : assert property (@(posedge clk) disable iff (reset) !(push && fifo_full));

endmodule
